spu32_cpu_mulpipe: RTL and testbench

SPU32_CPU_MULPIPE -- requirements
Module: spu32_cpu_mulpipe

---
 rtl/spu32_cpu_mulpipe.sv | 102 ++++++++++
 tb/tb_spu32_cpu_mulpipe.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/spu32_cpu_mulpipe.sv
// Pipelined WIDTH x WIDTH multiplier for the SPU32 ALU (MUL/MULH/MULHSU/MULHU).
// One operation in flight; result strobed on O_valid LATENCY cycles after accept.

`ifndef ALUOP_MUL
`define ALUOP_MUL    4'b1010
`endif
`ifndef ALUOP_MULH
`define ALUOP_MULH   4'b1011
`endif
`ifndef ALUOP_MULHSU
`define ALUOP_MULHSU 4'b1100
`endif
`ifndef ALUOP_MULHU
`define ALUOP_MULHU  4'b1101
`endif

module spu32_cpu_mulpipe #(
   parameter int unsigned WIDTH   = 32,
   parameter int unsigned LATENCY = 3
) (
   input  logic                 I_clk,
   input  logic                 I_reset_n,
   input  logic                 I_en,
   input  logic [3:0]           I_op,
   input  logic [WIDTH-1:0]     I_s1,
   input  logic [WIDTH-1:0]     I_s2,
   output logic [2*WIDTH-1:0]   O_result,
   output logic                 O_busy,
   output logic                 O_valid
);

   if (WIDTH < 8 || WIDTH > 64) begin : g_bad_width
      $error("spu32_cpu_mulpipe: WIDTH must be in 8..64");
   end
   if (LATENCY < 1 || LATENCY > 4) begin : g_bad_latency
      $error("spu32_cpu_mulpipe: LATENCY must be in 1..4");
   end

   logic                 s1_signed;
   logic                 s2_signed;
   logic                 accept;
   logic [2*WIDTH-1:0]   prod_raw;
   logic [2*WIDTH-1:0]   corr1;
   logic [2*WIDTH-1:0]   corr2;
   logic [2*WIDTH-1:0]   prod;
   logic [2*WIDTH-1:0]   data_q [LATENCY];
   logic [LATENCY-1:0]   vld_q;

   always_comb begin
      s1_signed = 1'b0;
      s2_signed = 1'b0;
      case (I_op)
         `ALUOP_MULH: begin
            s1_signed = 1'b1;
            s2_signed = 1'b1;
         end
         `ALUOP_MULHSU: s1_signed = 1'b1;
         default: ;
      endcase
   end

   // Signed product = unsigned product minus (other operand << WIDTH) for each negative signed operand.
   always_comb begin
      prod_raw = {{WIDTH{1'b0}}, I_s1} * {{WIDTH{1'b0}}, I_s2};
      corr1    = (s1_signed && I_s1[WIDTH-1]) ? {I_s2, {WIDTH{1'b0}}} : '0;
      corr2    = (s2_signed && I_s2[WIDTH-1]) ? {I_s1, {WIDTH{1'b0}}} : '0;
      prod     = prod_raw - corr1 - corr2;
   end

   always_comb begin
      O_busy = 1'b0;
      for (int unsigned i = 0; i + 1 < LATENCY; i++) begin
         O_busy = O_busy | vld_q[i];
      end
   end

   assign accept   = I_en & ~O_busy;
   assign O_valid  = vld_q[LATENCY-1];
   assign O_result = data_q[LATENCY-1];

   // Each stage loads only when a token arrives, so the last stage holds its value between strobes.
   always_ff @(posedge I_clk) begin
      if (!I_reset_n) begin
         vld_q <= '0;
         for (int unsigned i = 0; i < LATENCY; i++) begin
            data_q[i] <= '0;
         end
      end else begin
         vld_q[0] <= accept;
         if (accept) begin
            data_q[0] <= prod;
         end
         for (int unsigned i = 1; i < LATENCY; i++) begin
            vld_q[i] <= vld_q[i-1];
            if (vld_q[i-1]) begin
               data_q[i] <= data_q[i-1];
            end
         end
      end
   end

endmodule

// File: tb/tb_spu32_cpu_mulpipe.sv
// Directed bench for spu32_cpu_mulpipe: 32-bit/LATENCY=3 and 8-bit/LATENCY=1 instances.

`ifndef ALUOP_MUL
`define ALUOP_MUL    4'b1010
`endif
`ifndef ALUOP_MULH
`define ALUOP_MULH   4'b1011
`endif
`ifndef ALUOP_MULHSU
`define ALUOP_MULHSU 4'b1100
`endif
`ifndef ALUOP_MULHU
`define ALUOP_MULHU  4'b1101
`endif

module tb_spu32_cpu_mulpipe;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic        en3;
   logic [3:0]  op3;
   logic [31:0] a3, b3;
   logic [63:0] res3;
   logic        busy3, valid3;

   logic        en1;
   logic [3:0]  op1;
   logic [7:0]  a1, b1;
   logic [15:0] res1;
   logic        busy1, valid1;

   int unsigned vectors = 0;
   int unsigned miscompares = 0;

   spu32_cpu_mulpipe #(.WIDTH(32), .LATENCY(3)) dut3 (
      .I_clk(clk), .I_reset_n(rst_n), .I_en(en3), .I_op(op3), .I_s1(a3), .I_s2(b3),
      .O_result(res3), .O_busy(busy3), .O_valid(valid3)
   );

   spu32_cpu_mulpipe #(.WIDTH(8), .LATENCY(1)) dut1 (
      .I_clk(clk), .I_reset_n(rst_n), .I_en(en1), .I_op(op1), .I_s1(a1), .I_s2(b1),
      .O_result(res1), .O_busy(busy1), .O_valid(valid1)
   );

   task automatic chk_word(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk_bit(input string tag, input logic obs, input logic exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [63:0] ref_mul(input logic [3:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
      logic [63:0] ea, eb;
      ea = {32'b0, a};
      eb = {32'b0, b};
      if (op == `ALUOP_MULH || op == `ALUOP_MULHSU) ea = {{32{a[31]}}, a};
      if (op == `ALUOP_MULH) eb = {{32{b[31]}}, b};
      return ea * eb;
   endfunction

   // One isolated op on the 32-bit unit: full timing check plus scrambled inputs after accept.
   task automatic run3(input string tag, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [63:0] exp);
      op3 = op; a3 = a; b3 = b; en3 = 1'b1;
      tick();
      en3 = 1'b0; op3 = ~op; a3 = ~a; b3 = b ^ 32'h5a5a_5a5a;
      chk_bit({tag, " busy c1"}, busy3, 1'b1);
      chk_bit({tag, " valid c1"}, valid3, 1'b0);
      en3 = 1'b1;
      tick();
      en3 = 1'b0;
      chk_bit({tag, " busy c2"}, busy3, 1'b1);
      chk_bit({tag, " valid c2"}, valid3, 1'b0);
      tick();
      chk_bit({tag, " busy c3"}, busy3, 1'b0);
      chk_bit({tag, " valid c3"}, valid3, 1'b1);
      chk_word({tag, " result"}, res3, exp);
      tick();
      chk_bit({tag, " idle busy"}, busy3, 1'b0);
      chk_bit({tag, " idle valid"}, valid3, 1'b0);
      chk_word({tag, " result hold"}, res3, exp);
   endtask

   logic [31:0] va [9];
   logic [31:0] vb [9];
   logic [3:0]  ops [5];
   logic [63:0] pend;
   logic [63:0] exp_res;
   int          age;
   int          cyc;
   logic        accepted;

   initial begin
      va  = '{32'h0000_0003, 32'h1111_1111, 32'h2222_2222, 32'hFFFF_FFFF, 32'h0BAD_F00D,
              32'h0000_0000, 32'h8000_0001, 32'h7777_7777, 32'h0000_0010};
      vb  = '{32'h0000_0005, 32'h3333_3333, 32'h4444_4444, 32'h0000_0002, 32'h5555_5555,
              32'h6666_6666, 32'hFFFF_FFFF, 32'h8888_8888, 32'h0000_0020};
      ops = '{`ALUOP_MUL, `ALUOP_MULH, `ALUOP_MULHSU, `ALUOP_MULHU, 4'h0};

      // Reset with requests asserted: reset must win.
      rst_n = 1'b0;
      en3 = 1'b1; op3 = `ALUOP_MULHU; a3 = 32'hFFFF_FFFF; b3 = 32'hFFFF_FFFF;
      en1 = 1'b1; op1 = `ALUOP_MULHU; a1 = 8'hFF; b1 = 8'hFF;
      tick();
      tick();
      chk_bit("rst busy3", busy3, 1'b0);
      chk_bit("rst valid3", valid3, 1'b0);
      chk_word("rst res3", res3, 64'h0);
      chk_bit("rst busy1", busy1, 1'b0);
      chk_bit("rst valid1", valid1, 1'b0);
      chk_word("rst res1", {48'b0, res1}, 64'h0);

      // First cycle out of reset: both units accept.
      rst_n = 1'b1;
      op3 = `ALUOP_MULH; a3 = 32'hFFFF_FFFF; b3 = 32'hFFFF_FFFF; en3 = 1'b1;
      op1 = `ALUOP_MULH; a1 = 8'h80; b1 = 8'h80; en1 = 1'b1;
      tick();
      en3 = 1'b0; a3 = 32'h1234_5678;
      chk_bit("l1 valid a", valid1, 1'b1);
      chk_bit("l1 busy a", busy1, 1'b0);
      chk_word("l1 mulh 80x80", {48'b0, res1}, 64'h4000);
      chk_bit("first busy3", busy3, 1'b1);
      op1 = `ALUOP_MULHU; a1 = 8'hFF; b1 = 8'hFF;
      tick();
      chk_bit("l1 valid b", valid1, 1'b1);
      chk_bit("l1 busy b", busy1, 1'b0);
      chk_word("l1 mulhu ffxff", {48'b0, res1}, 64'hFE01);
      chk_bit("first valid3 early", valid3, 1'b0);
      op1 = `ALUOP_MULHSU; a1 = 8'hFF; b1 = 8'hFF;
      tick();
      chk_bit("l1 valid c", valid1, 1'b1);
      chk_word("l1 mulhsu ffxff", {48'b0, res1}, 64'hFF01);
      chk_bit("first valid3", valid3, 1'b1);
      chk_bit("first busy3 done", busy3, 1'b0);
      chk_word("mulh -1x-1", res3, 64'h0000_0000_0000_0001);
      en1 = 1'b0; a1 = 8'h12;
      tick();
      chk_bit("l1 idle valid", valid1, 1'b0);
      chk_bit("l1 idle busy", busy1, 1'b0);
      chk_word("l1 hold", {48'b0, res1}, 64'hFF01);
      chk_bit("first idle valid3", valid3, 1'b0);

      run3("mulhu -1x-1",  `ALUOP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
      run3("mulhsu -1x-1", `ALUOP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFF_0000_0001);
      run3("mulh min^2",   `ALUOP_MULH,   32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);
      run3("mul ffx2",     `ALUOP_MUL,    32'hFFFF_FFFF, 32'h0000_0002, 64'h0000_0001_FFFF_FFFE);
      run3("mulh -2x3",    `ALUOP_MULH,   32'hFFFF_FFFE, 32'h0000_0003, 64'hFFFF_FFFF_FFFF_FFFA);
      run3("mulhsu 2xmsb", `ALUOP_MULHSU, 32'h0000_0002, 32'h8000_0000, 64'h0000_0001_0000_0000);
      run3("other op",     4'h0,          32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);

      // Back-to-back with I_en held high: accepts at 0,3,6.
      en3 = 1'b1; op3 = `ALUOP_MULHU;
      for (int k = 0; k < 9; k++) begin
         a3 = va[k]; b3 = vb[k];
         tick();
         cyc = k + 1;
         chk_bit("b2b busy", busy3, (cyc % 3) != 0);
         chk_bit("b2b valid", valid3, (cyc % 3) == 0);
         if ((cyc % 3) == 0) chk_word("b2b result", res3, {32'b0, va[cyc-3]} * {32'b0, vb[cyc-3]});
      end
      en3 = 1'b0;
      tick();
      chk_bit("b2b end busy", busy3, 1'b0);
      chk_bit("b2b end valid", valid3, 1'b0);
      chk_word("b2b end hold", res3, {32'b0, va[6]} * {32'b0, vb[6]});

      // Reset one cycle after accept aborts the operation.
      op3 = `ALUOP_MULHU; a3 = 32'hFFFF_FFFF; b3 = 32'hFFFF_FFFF; en3 = 1'b1;
      tick();
      en3 = 1'b0; rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      chk_bit("abort busy", busy3, 1'b0);
      chk_bit("abort valid", valid3, 1'b0);
      chk_word("abort res", res3, 64'h0);
      for (int k = 0; k < 4; k++) begin
         tick();
         chk_bit("abort no valid", valid3, 1'b0);
         chk_bit("abort no busy", busy3, 1'b0);
         chk_word("abort res stays 0", res3, 64'h0);
      end

      // Random mixed ops, I_en toggling while busy, against a signed/unsigned reference.
      age = 0;
      exp_res = 64'h0;
      pend = 64'h0;
      for (int n = 0; n < 80; n++) begin
         en3 = 1'($urandom_range(0, 1));
         op3 = ops[$urandom_range(0, 4)];
         a3 = ($urandom_range(0, 3) == 0) ? 32'h8000_0000 : $urandom;
         b3 = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
         accepted = en3 && (age == 0 || age == 3);
         if (accepted) begin
            pend = ref_mul(op3, a3, b3);
            age = 1;
         end else if (age == 3) begin
            age = 0;
         end else if (age != 0) begin
            age++;
         end
         tick();
         if (age == 3) exp_res = pend;
         chk_bit("rand busy", busy3, age == 1 || age == 2);
         chk_bit("rand valid", valid3, age == 3);
         chk_word("rand result", res3, exp_res);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
